// File: rtl/i2c_slave.sv
// -----------------------------------------------------------------------------
// i2c_slave : I2C target with a register-pointer model.
//
// Oversamples SCL/SDA on i_clk, detects START/STOP, and answers to DEVICE_ADDR.
// The first byte written after the address sets the register pointer. Every
// later written byte goes out on the write port and every byte read comes in
// on the read port. The pointer auto-increments and wraps. This target never
// stretches the clock.
//
// Ports:
//   i_clk, i_reset         system clock, synchronous active-high reset
//   i2c_scl                bus clock (input only)
//   i2c_sda                bus data, open-drain (driven 0 or z)
//   o_wr_en/addr/data      one-cycle register write request
//   o_rd_en/addr           one-cycle register read request
//   i_rd_data              read data, valid the cycle after o_rd_en
//   o_busy                 addressed and transfer in progress
//   o_start_det/o_stop_det bus condition pulses
//   o_nack_rx              master NACKed a read byte
// -----------------------------------------------------------------------------
module i2c_slave #(
    parameter logic [6:0]  DEVICE_ADDR = 7'h50,
    parameter int unsigned REG_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i2c_scl,
    inout  wire                   i2c_sda,
    output logic                  o_wr_en,
    output logic [REG_WIDTH-1:0]  o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_rd_en,
    output logic [REG_WIDTH-1:0]  o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_busy,
    output logic                  o_start_det,
    output logic                  o_stop_det,
    output logic                  o_nack_rx
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_IGNORE   = 3'd3,
        ST_WR_BYTE  = 3'd4,
        ST_WR_ACK   = 3'd5,
        ST_RD_BYTE  = 3'd6,
        ST_RD_ACK   = 3'd7
    } state_t;

    // synchronizers plus one history stage each
    logic scl_meta_q, scl_sync_q, scl_hist_q;
    logic sda_meta_q, sda_sync_q, sda_hist_q;

    state_t                state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-2:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic                  rw_q, rw_d;
    logic                  first_byte_q, first_byte_d;
    // ACK states: ACK is being driven / sampled. RD_BYTE: all 8 bits clocked out.
    logic                  slot_q, slot_d;
    logic                  load_q, load_d;
    logic [REG_WIDTH-1:0]  ptr_q, ptr_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  busy_q, busy_d;
    logic                  wr_en_q, wr_en_d;
    logic [REG_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  rd_en_q, rd_en_d;
    logic [REG_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic                  start_det_q, start_det_d;
    logic                  stop_det_q, stop_det_d;
    logic                  nack_rx_q, nack_rx_d;

    logic                  fetch_s;
    logic                  sda_in_s;
    logic                  scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [DATA_WIDTH-1:0] byte_in_s;

    assign sda_in_s   = i2c_sda;
    assign i2c_sda    = sda_oe_q ? 1'b0 : 1'bz;
    assign scl_rise_s = scl_sync_q & ~scl_hist_q;
    assign scl_fall_s = ~scl_sync_q & scl_hist_q;
    assign start_s    = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
    assign stop_s     = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;
    assign byte_in_s  = {shift_q, sda_sync_q};

    assign o_wr_en     = wr_en_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_rd_en     = rd_en_q;
    assign o_rd_addr   = rd_addr_q;
    assign o_busy      = busy_q;
    assign o_start_det = start_det_q;
    assign o_stop_det  = stop_det_q;
    assign o_nack_rx   = nack_rx_q;

    // Next-state logic: bus conditions first, then per-state bit handling.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rw_d         = rw_q;
        first_byte_d = first_byte_q;
        slot_d       = slot_q;
        ptr_d        = ptr_q;
        sda_oe_d     = sda_oe_q;
        busy_d       = busy_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rd_addr_d    = rd_addr_q;
        wr_en_d      = 1'b0;
        rd_en_d      = 1'b0;
        start_det_d  = 1'b0;
        stop_det_d   = 1'b0;
        nack_rx_d    = 1'b0;
        fetch_s      = 1'b0;
        // read data arrives the cycle after o_rd_en
        load_d       = rd_en_q;
        if (load_q) begin
            tx_d = i_rd_data;
        end else begin
            tx_d = tx_q;
        end

        if (start_s) begin
            start_det_d = 1'b1;
            state_d     = ST_ADDR;
            bit_cnt_d   = 3'd0;
            slot_d      = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
        end else if (stop_s) begin
            stop_det_d = 1'b1;
            state_d    = ST_IDLE;
            slot_d     = 1'b0;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise_s) begin
                        shift_d   = byte_in_s[DATA_WIDTH-2:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q != 3'd7) begin
                            state_d = ST_ADDR;
                        end else if (byte_in_s[DATA_WIDTH-1:1] == DEVICE_ADDR) begin
                            state_d      = ST_ADDR_ACK;
                            rw_d         = byte_in_s[0];
                            first_byte_d = 1'b1;
                            busy_d       = 1'b1;
                            slot_d       = 1'b0;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
                ST_ADDR_ACK, ST_WR_ACK: begin
                    if (scl_fall_s && !slot_q) begin
                        sda_oe_d = 1'b1;
                        slot_d   = 1'b1;
                    end else if (scl_rise_s && slot_q && rw_q) begin
                        // prefetch so bit7 is ready on the closing fall
                        fetch_s = 1'b1;
                    end else if (scl_fall_s && slot_q) begin
                        slot_d    = 1'b0;
                        bit_cnt_d = 3'd0;
                        if (rw_q) begin
                            state_d  = ST_RD_BYTE;
                            sda_oe_d = ~tx_q[DATA_WIDTH-1];
                        end else begin
                            state_d  = ST_WR_BYTE;
                            sda_oe_d = 1'b0;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise_s) begin
                        shift_d   = byte_in_s[DATA_WIDTH-2:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q != 3'd7) begin
                            state_d = ST_WR_BYTE;
                        end else if (first_byte_q) begin
                            ptr_d        = REG_WIDTH'(byte_in_s);
                            first_byte_d = 1'b0;
                            state_d      = ST_WR_ACK;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = byte_in_s;
                            ptr_d     = ptr_q + REG_WIDTH'(1'b1);
                            state_d   = ST_WR_ACK;
                        end
                    end else begin
                        state_d = ST_WR_BYTE;
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_rise_s) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        slot_d    = (bit_cnt_q == 3'd7);
                    end else if (scl_fall_s && slot_q) begin
                        sda_oe_d = 1'b0;
                        slot_d   = 1'b0;
                        state_d  = ST_RD_ACK;
                    end else if (scl_fall_s) begin
                        // open-drain: pull low for 0, release for 1
                        sda_oe_d = ~tx_q[3'd7 - bit_cnt_q];
                    end else begin
                        state_d = ST_RD_BYTE;
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise_s && !slot_q) begin
                        if (sda_sync_q) begin
                            nack_rx_d = 1'b1;
                            state_d   = ST_IGNORE;
                        end else begin
                            fetch_s = 1'b1;
                            slot_d  = 1'b1;
                        end
                    end else if (scl_fall_s && slot_q) begin
                        slot_d    = 1'b0;
                        bit_cnt_d = 3'd0;
                        sda_oe_d  = ~tx_q[DATA_WIDTH-1];
                        state_d   = ST_RD_BYTE;
                    end else begin
                        state_d = ST_RD_ACK;
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end

        if (fetch_s) begin
            rd_en_d   = 1'b1;
            rd_addr_d = ptr_q;
            ptr_d     = ptr_q + REG_WIDTH'(1'b1);
        end else begin
            rd_en_d = 1'b0;
        end
    end

    // State, synchronizer and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            scl_meta_q   <= 1'b1;
            scl_sync_q   <= 1'b1;
            scl_hist_q   <= 1'b1;
            sda_meta_q   <= 1'b1;
            sda_sync_q   <= 1'b1;
            sda_hist_q   <= 1'b1;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= '0;
            tx_q         <= '0;
            rw_q         <= 1'b0;
            first_byte_q <= 1'b0;
            slot_q       <= 1'b0;
            load_q       <= 1'b0;
            ptr_q        <= '0;
            sda_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            start_det_q  <= 1'b0;
            stop_det_q   <= 1'b0;
            nack_rx_q    <= 1'b0;
        end else begin
            scl_meta_q   <= i2c_scl;
            scl_sync_q   <= scl_meta_q;
            scl_hist_q   <= scl_sync_q;
            sda_meta_q   <= sda_in_s;
            sda_sync_q   <= sda_meta_q;
            sda_hist_q   <= sda_sync_q;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            rw_q         <= rw_d;
            first_byte_q <= first_byte_d;
            slot_q       <= slot_d;
            load_q       <= load_d;
            ptr_q        <= ptr_d;
            sda_oe_q     <= sda_oe_d;
            busy_q       <= busy_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            start_det_q  <= start_det_d;
            stop_det_q   <= stop_det_d;
            nack_rx_q    <= nack_rx_d;
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave : directed bench for i2c_slave. The bench acts as the bus
// master. A transaction-level target model predicts ACKs, register writes,
// read requests and read data. A per-cycle compare process checks the DUT
// against that model. Literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_i2c_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       m_sda_low;
    wire        sda_w;
    logic       wr_en, rd_en, busy, start_det, stop_det, nack_rx;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

    logic       rd_mode;
    logic       quiet;
    logic [7:0] reg_mem [256];

    int checks = 0;
    int errors = 0;
    int n_start = 0, n_stop = 0, n_nack = 0;

    // transaction-level target model
    logic [7:0]  mdl_ptr;
    logic        mdl_first, mdl_active, mdl_read;
    logic [7:0]  mdl_mem [256];
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  exp_rdata[$];
    logic [15:0] wr_log[$];
    logic [7:0]  rd_log[$];

    pullup (sda_w);
    assign sda_w   = m_sda_low ? 1'b0 : 1'bz;
    assign rd_data = rd_mode ? reg_mem[rd_addr] : rd_addr + 8'h20;

    always #5 clk = ~clk;

    i2c_slave #(.DEVICE_ADDR(7'h50), .REG_WIDTH(8), .DATA_WIDTH(8)) dut (
        .i_clk(clk), .i_reset(rst), .i2c_scl(scl), .i2c_sda(sda_w),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
        .o_busy(busy), .o_start_det(start_det), .o_stop_det(stop_det),
        .o_nack_rx(nack_rx)
    );

    // register bank behind the target
    always @(posedge clk) begin
        if (wr_en) reg_mem[wr_addr] <= wr_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // per-cycle compare against the model
    logic [15:0] cmp_e;
    logic        m_low_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", {24'h0, wr_addr}, 32'hFFFF);
                end else begin
                    cmp_e = exp_wr.pop_front();
                    chk("wr_addr", wr_addr, cmp_e[15:8]);
                    chk("wr_data", wr_data, cmp_e[7:0]);
                end
                wr_log.push_back({wr_addr, wr_data});
            end
            if (rd_en) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected", {24'h0, rd_addr}, 32'hFFFF);
                end else begin
                    chk("rd_addr", rd_addr, exp_rd.pop_front());
                end
                rd_log.push_back(rd_addr);
            end
            if (quiet && !m_sda_low && !m_low_prev) begin
                chk("quiet_sda", sda_w, 1);
                chk("quiet_busy", busy, 0);
            end
            n_start += int'(start_det);
            n_stop  += int'(stop_det);
            n_nack  += int'(nack_rx);
        end
        m_low_prev <= m_sda_low;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one SCL period: drive during low, sample mid-high
    task automatic clk_bit(input logic drv_low, output logic smp);
        m_sda_low = drv_low;
        wait_clk(5);
        scl = 1'b1;
        wait_clk(5);
        smp = sda_w;
        wait_clk(5);
        scl = 1'b0;
        wait_clk(5);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0;
        scl       = 1'b1;
        wait_clk(5);
        m_sda_low = 1'b1;
        wait_clk(10);
        scl = 1'b0;
        wait_clk(5);
    endtask

    task automatic bus_rstart();
        m_sda_low = 1'b0;
        wait_clk(5);
        scl = 1'b1;
        wait_clk(10);
        m_sda_low = 1'b1;
        wait_clk(10);
        scl = 1'b0;
        wait_clk(5);
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1;
        wait_clk(5);
        scl = 1'b1;
        wait_clk(10);
        m_sda_low = 1'b0;
        wait_clk(10);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(~b[i], s);
        clk_bit(1'b0, s);
        ack = ~s;
    endtask

    task automatic mdl_fetch();
        exp_rd.push_back(mdl_ptr);
        exp_rdata.push_back(rd_mode ? mdl_mem[mdl_ptr] : mdl_ptr + 8'h20);
        mdl_ptr = mdl_ptr + 8'h01;
    endtask

    task automatic mdl_reset();
        mdl_ptr    = 8'h00;
        mdl_active = 1'b0;
        mdl_first  = 1'b0;
        exp_rdata.delete();
    endtask

    task automatic do_addr(input logic [7:0] a);
        logic ack;
        mdl_active = (a[7:1] == 7'h50);
        mdl_read   = a[0];
        if (mdl_active && !mdl_read) mdl_first = 1'b1;
        if (mdl_active && mdl_read) mdl_fetch();
        write_byte(a, ack);
        chk("addr_ack", ack, mdl_active);
    endtask

    task automatic do_wr(input logic [7:0] b);
        logic ack;
        logic exp_ack;
        exp_ack = mdl_active;
        if (mdl_active) begin
            if (mdl_first) begin
                mdl_ptr   = b;
                mdl_first = 1'b0;
            end else begin
                exp_wr.push_back({mdl_ptr, b});
                mdl_mem[mdl_ptr] = b;
                mdl_ptr = mdl_ptr + 8'h01;
            end
        end
        write_byte(b, ack);
        chk("data_ack", ack, exp_ack);
    endtask

    task automatic do_rd(input logic last, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b0, s);
            b[i] = s;
        end
        if (exp_rdata.size() == 0) chk("rd_model_empty", {24'h0, b}, 32'hFFFF);
        else chk("rd_data", b, exp_rdata.pop_front());
        if (!last) mdl_fetch();
        clk_bit(~last, s);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pulses"}, {start_det, stop_det, nack_rx}, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_sda"}, sda_w, 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b0, b1, b2;
        int base_wr, base_rd, base_stop, base_start, base_nack;

        rst = 1'b1; scl = 1'b1; m_sda_low = 1'b0; rd_mode = 1'b0; quiet = 1'b0;
        mdl_reset();
        wait_clk(4);
        check_reset_vals("reset");
        rst = 1'b0;
        wait_clk(20);

        // write: pointer 0x10, data 5A, 3C
        base_wr = wr_log.size(); base_stop = n_stop; base_start = n_start;
        bus_start(); do_addr(8'hA0); do_wr(8'h10); do_wr(8'h5A); do_wr(8'h3C);
        chk("busy_active", busy, 1);
        bus_stop(); wait_clk(5);
        chk("busy_after_stop", busy, 0);
        chk("stop_count", n_stop - base_stop, 1);
        chk("start_count", n_start - base_start, 1);
        chk("wr_count", wr_log.size() - base_wr, 2);
        if (wr_log.size() >= base_wr + 2) begin
            chk("wr0_lit", wr_log[base_wr], 16'h105A);
            chk("wr1_lit", wr_log[base_wr + 1], 16'h113C);
        end

        // pointer write + repeated START read of two bytes
        base_rd = rd_log.size(); base_nack = n_nack;
        bus_start(); do_addr(8'hA0); do_wr(8'h20);
        bus_rstart(); do_addr(8'hA1);
        do_rd(1'b0, b0); do_rd(1'b1, b1);
        chk("rd0_lit", b0, 8'h40);
        chk("rd1_lit", b1, 8'h41);
        chk("nack_count", n_nack - base_nack, 1);
        wait_clk(3);
        chk("sda_after_nack", sda_w, 1);
        chk("rd_count", rd_log.size() - base_rd, 2);
        if (rd_log.size() >= base_rd + 2) begin
            chk("rd_addr0_lit", rd_log[base_rd], 8'h20);
            chk("rd_addr1_lit", rd_log[base_rd + 1], 8'h21);
        end
        bus_stop(); wait_clk(5);

        // address mismatch and general call: never acknowledged
        base_wr = wr_log.size();
        quiet = 1'b1;
        bus_start(); do_addr(8'hB0); do_wr(8'h01); bus_stop();
        bus_start(); do_addr(8'h00); do_wr(8'h02); bus_stop();
        wait_clk(5);
        quiet = 1'b0;
        chk("mismatch_no_wr", wr_log.size() - base_wr, 0);

        // pointer wrap FF -> 00
        base_wr = wr_log.size();
        bus_start(); do_addr(8'hA0); do_wr(8'hFF); do_wr(8'h11); do_wr(8'h22); bus_stop();
        wait_clk(5);
        if (wr_log.size() >= base_wr + 2) begin
            chk("wrap0_lit", wr_log[base_wr], 16'hFF11);
            chk("wrap1_lit", wr_log[base_wr + 1], 16'h0022);
        end else begin
            chk("wrap_count", wr_log.size() - base_wr, 2);
        end

        // reset while the target drives a 0 bit (byte 0x50, bit7 = 0)
        bus_start(); do_addr(8'hA0); do_wr(8'h30);
        bus_rstart(); do_addr(8'hA1);
        chk("drive_zero_lit", sda_w, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_sda_released", sda_w, 1);
        wait_clk(2);
        check_reset_vals("midrst");
        mdl_reset();
        rst = 1'b0;
        wait_clk(5);
        bus_stop(); wait_clk(5);
        // pointer cleared by reset: read returns register 0x00 -> 0x20
        base_rd = rd_log.size();
        bus_start(); do_addr(8'hA1); do_rd(1'b1, b0); bus_stop();
        chk("post_rst_rd_lit", b0, 8'h20);
        if (rd_log.size() > base_rd) chk("post_rst_addr_lit", rd_log[base_rd], 8'h00);
        bus_start(); do_addr(8'hA0); do_wr(8'h05); do_wr(8'h77); bus_stop();
        wait_clk(5);
        if (wr_log.size() > 0) chk("post_rst_wr_lit", wr_log[wr_log.size() - 1], 16'h0577);

        // register bank round trip: write 3 bytes, read them back
        rd_mode = 1'b1;
        bus_start(); do_addr(8'hA0); do_wr(8'h40); do_wr(8'hDE); do_wr(8'hAD); do_wr(8'hBE); bus_stop();
        bus_start(); do_addr(8'hA0); do_wr(8'h40);
        bus_rstart(); do_addr(8'hA1);
        do_rd(1'b0, b0); do_rd(1'b0, b1); do_rd(1'b1, b2);
        bus_stop(); wait_clk(5);
        chk("loop0_lit", b0, 8'hDE);
        chk("loop1_lit", b1, 8'hAD);
        chk("loop2_lit", b2, 8'hBE);
        chk("busy_end", busy, 0);

        chk("exp_wr_drained", exp_wr.size(), 0);
        chk("exp_rd_drained", exp_rd.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (responder) for the same bus our master drives. Register-pointer model.
- Oversamples SCL/SDA on i_clk, detects START/STOP and matches a 7-bit address.
- First written byte sets the register pointer; later writes and all reads go to/from a local register-file interface, with the pointer auto-incrementing.
- No clock stretching. Sits beside user register banks on the far end of the bus, or in loopback benches against i2c_master.

Parameters:
- DEVICE_ADDR, 7'h50, 7-bit address this target answers to.
- REG_WIDTH, 8, register pointer / address width.
- DATA_WIDTH, 8, data byte width (fixed at 8 for I2C; any other value is unsupported).

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  synchronous, active-high reset.
- i2c_scl  input  1  bus clock (target never drives SCL).
- i2c_sda  inout  1  bus data; driven 1'b0 or 1'bz only, never 1'b1.
- o_wr_en  output  1  one-cycle pulse: o_wr_data is to be written at o_wr_addr.
- o_wr_addr  output  REG_WIDTH  write register address.
- o_wr_data  output  DATA_WIDTH  write data.
- o_rd_en  output  1  one-cycle pulse requesting the byte at o_rd_addr.
- o_rd_addr  output  REG_WIDTH  read register address.
- i_rd_data  input  DATA_WIDTH  read data; must be valid the cycle after o_rd_en.
- o_busy  output  1  high from address match until STOP or START.
- o_start_det  output  1  one-cycle pulse on every START or repeated START.
- o_stop_det  output  1  one-cycle pulse on every STOP.
- o_nack_rx  output  1  one-cycle pulse when the master NACKs a read byte.

Behaviour:
- Reset (synchronous): sets the following; pointer is cleared only by reset.
  - i2c_sda = z; all pulse outputs = 0.
  - o_busy = 0; o_wr_addr, o_wr_data, o_rd_addr = 0; pointer = 0.
  - State = IDLE.
  - Reset asserted mid-transfer: bus released the same edge.
- Input sampling:
  - 2-flop synchronizer on SCL and SDA, plus one history flop each.
  - Edges are derived from the synchronized values; detection latency is 3 i_clk.
  - Requirement on bus timing: SCL high and low phases each ≥ 8 i_clk.
- Bus condition detection:
  - START = SDA falls while SCL high; STOP = SDA rises while SCL high.
  - Both are detected in every state and take priority over bit processing.
  - START → ADDR with bit_cnt = 0 and SDA released.
  - STOP → IDLE with SDA released and o_busy = 0.
- Bit timing:
  - Data is sampled on the synchronized SCL rising edge.
  - The target changes SDA only on the synchronized SCL falling edge.
- States:
  - IDLE: SDA z; wait for START.
  - ADDR: shift 8 bits MSB first. After the 8th rising edge, compare [7:1] with DEVICE_ADDR.
    - Match → ADDR_ACK, latch rw = bit0, o_busy = 1.
    - Mismatch → IGNORE.
  - IGNORE: SDA z; leave only on START or STOP.
  - ADDR_ACK: on the next SCL fall, drive SDA 0; hold for one SCL high; release on the following fall.
    - rw = 0 → WR_BYTE, with first_byte = 1.
    - rw = 1 → pulse o_rd_en with o_rd_addr = pointer; load i_rd_data next cycle; pointer += 1; → RD_BYTE, driving bit7 on that same fall.
  - WR_BYTE: shift 8 bits, then → WR_ACK (ACK driven exactly as in ADDR_ACK).
    - On the 8th rising edge with first_byte = 1: pointer = byte; first_byte = 0.
    - On the 8th rising edge otherwise: pulse o_wr_en with o_wr_addr = pointer and o_wr_data = byte; pointer += 1.
    - After the ACK → WR_BYTE.
  - RD_BYTE: on each SCL fall, drive 0 for a 0 bit and z for a 1 bit; release SDA after bit0's falling edge. → RD_ACK.
  - RD_ACK: sample SDA on SCL rise.
    - SDA = 0 (ACK) → fetch the next byte as above; → RD_BYTE.
    - SDA = 1 (NACK) → pulse o_nack_rx; → IGNORE (SDA z until STOP/START).
- Arithmetic: pointer increment wraps modulo 2^REG_WIDTH (FF → 00).
- Repeated START:
  - Pointer is retained, so a write of the pointer followed by a repeated-START read returns the register at that pointer.
  - A START during RD_BYTE releases SDA immediately.
- Extra bits:
  - General call (addr 0) is not acknowledged unless DEVICE_ADDR = 0.
  - A 9th or later SCL without ACK handling cannot occur, because state is always defined by bit_cnt 0..7 plus the ACK slot.

Test Plan:
- Write: START, 0xA0, 0x10, 0x5A, 0x3C, STOP.
  - Required: ACK on all 4 bytes.
  - o_wr_en pulses twice: (0x10, 0x5A) then (0x11, 0x3C).
  - o_stop_det pulses once; o_busy = 0 after STOP.
- Pointer write + repeated START read: START, 0xA0, 0x20, rSTART, 0xA1, read 2 bytes (ACK, NACK), with i_rd_data = 0x20 + addr.
  - Required: o_rd_addr 0x20 then 0x21; bus returns 0x40, 0x41.
  - o_nack_rx pulses once; SDA z afterwards.
- Address mismatch: START, 0xB0, 0x01, STOP.
  - Required: SDA z throughout; no o_wr_en; o_busy stays 0.
- Pointer wrap: pointer set to 0xFF, then 2 writes.
  - Required: write addresses 0xFF then 0x00.
- Reset mid-read: assert i_reset while the target is driving a 0 bit.
  - Required: SDA z on the next i_clk; all outputs at reset values.
  - Next transaction succeeds normally.
- Loopback vs i2c_master (divider 250): register write then read-back of 3 bytes.
  - Required: data matches; master o_ack_error = 0.
